// File: rtl/keypad_event_encoder.sv
// Keypad/operator-switch conditioner: 2-flop sync, debounce, one-key-at-a-time
// FSM and a small FWFT event FIFO drained by valid/ready.
module keypad_event_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [11:0]                   sw,
  input  logic [7:0]                    dipsw,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [1:0]                    ev_kind,
  output logic [3:0]                    ev_code,
  output logic                          multi_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = PTR_W + 1;

  typedef enum logic {S_IDLE, S_HELD} state_t;

  logic [19:0]      w_raw;
  logic [19:0]      r_sync1, r_sync2, r_last, r_stable;
  logic [CNT_W-1:0] r_cnt;

  state_t           r_state, w_state_next;
  logic             w_push, w_multi, w_any, w_one;
  logic [1:0]       w_kind;
  logic [3:0]       w_code;

  logic [5:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr, r_rd;
  logic [CW-1:0]    r_count;
  logic [5:0]       r_hold;
  logic             r_ovf, r_merr;
  logic             w_valid, w_full, w_pop, w_wr;

  assign w_raw = {sw, dipsw};

  // Debounce: counter restarts on any sample change; stable loads once the
  // synchronized vector has been unchanged for DEBOUNCE_CYCLES comparisons.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_last   <= '0;
      r_stable <= '0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_last  <= r_sync2;
      if (r_sync2 != r_last)
        r_cnt <= '0;
      else if (r_cnt != '1)
        r_cnt <= r_cnt + CNT_W'(1);
      if ((r_sync2 == r_last) && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)))
        r_stable <= r_sync2;
    end
  end

  assign w_any = |r_stable;
  assign w_one = w_any && ((r_stable & (r_stable - 20'd1)) == '0);

  // Encoder only matters for a one-hot vector, so overlap order is irrelevant.
  always_comb begin
    w_kind = 2'b00;
    w_code = 4'd0;
    for (int unsigned d = 0; d < 10; d++) begin
      if (r_stable[5'(19 - d)]) begin
        w_kind = 2'b00;
        w_code = 4'(d);
      end
    end
    if (r_stable[9] || r_stable[8]) begin
      w_kind = 2'b10;
      w_code = 4'd0;
    end
    for (int unsigned k = 0; k < 8; k++) begin
      if (r_stable[3'(7 - k)]) begin
        w_kind = 2'b01;
        w_code = 4'(k);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    w_multi      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_one) begin
          w_push       = 1'b1;
          w_state_next = S_HELD;
        end else if (w_any) begin
          w_multi      = 1'b1;
          w_state_next = S_HELD;
        end
      end
      S_HELD: begin
        if (!w_any)
          w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_pop   = w_valid && ev_ready;
  assign w_wr    = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[r_wr] <= {w_kind, w_code};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_hold  <= '0;
      r_ovf   <= 1'b0;
      r_merr  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_merr  <= w_multi;
      if (w_wr)
        r_wr <= r_wr + PTR_W'(1);
      if (w_pop) begin
        r_rd   <= r_rd + PTR_W'(1);
        r_hold <= r_mem[r_rd];
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_push && !w_wr)
        r_ovf <= 1'b1;
    end
  end

  // Head is only read from memory while non-empty; otherwise the last popped event is held.
  assign ev_valid            = w_valid;
  assign {ev_kind, ev_code}  = w_valid ? r_mem[r_rd] : r_hold;
  assign multi_err           = r_merr;
  assign overflow            = r_ovf;
  assign fifo_count          = r_count;

endmodule

// File: tb/tb_keypad_event_encoder.sv
// Directed bench for keypad_event_encoder with a per-cycle behavioural model.
module tb_keypad_event_encoder;

  localparam int D     = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] sw = '0;
  logic [7:0]  dipsw = '0;
  logic        ev_ready = 1'b0;
  logic        ev_valid, multi_err, overflow;
  logic [1:0]  ev_kind;
  logic [3:0]  ev_code;
  logic [2:0]  fifo_count;

  keypad_event_encoder #(.DEBOUNCE_CYCLES(D), .CNT_W(16), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .sw(sw), .dipsw(dipsw),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_kind(ev_kind), .ev_code(ev_code),
    .multi_err(multi_err), .overflow(overflow), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int obs_valid = 0;
  int obs_merr  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: stable = synchronized sample once it has held for D+1 consecutive
  // samples; one event per press from idle; FIFO as a queue.
  logic [19:0] m_s1, m_stable;
  logic [19:0] m_hist[$];
  int          m_q[$];
  bit          m_idle, m_ovf, m_merr;
  int          m_hold;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1 = '0; m_stable = '0; m_hist = {20'd0, 20'd0};
      m_q.delete(); m_idle = 1; m_ovf = 0; m_merr = 0; m_hold = 0;
    end else begin
      bit pop, push, all_eq;
      int ev, ones;
      pop  = (m_q.size() != 0) && ev_ready;
      push = 0; ev = 0;
      ones = $countones(m_stable);
      m_merr = 0;
      if (m_idle) begin
        if (ones == 1) begin
          push = 1;
          for (int d = 0; d < 10; d++) if (m_stable[19-d]) ev = d;
          if (m_stable[9] || m_stable[8]) ev = 2 * 16;
          for (int k = 0; k < 8; k++) if (m_stable[7-k]) ev = 16 + k;
        end
        if (ones >= 2) m_merr = 1;
        if (ones != 0) m_idle = 0;
      end else if (ones == 0) begin
        m_idle = 1;
      end
      if (pop) m_hold = m_q.pop_front();
      if (push) begin
        if (m_q.size() < DEPTH) m_q.push_back(ev);
        else m_ovf = 1;
      end
      all_eq = (m_hist.size() >= D + 1);
      if (all_eq)
        for (int i = 1; i <= D; i++)
          if (m_hist[m_hist.size()-1-i] != m_hist[m_hist.size()-1]) all_eq = 0;
      if (all_eq) m_stable = m_hist[m_hist.size()-1];
      m_hist.push_back(m_s1);
      if (m_hist.size() > D + 1) void'(m_hist.pop_front());
      m_s1 = {sw, dipsw};
    end
  end

  always @(negedge clk) begin
    int head;
    head = (m_q.size() != 0) ? m_q[0] : m_hold;
    chk("ev_valid", int'(ev_valid), int'(m_q.size() != 0));
    chk("ev_kind", int'(ev_kind), head / 16);
    chk("ev_code", int'(ev_code), head % 16);
    chk("multi_err", int'(multi_err), int'(m_merr));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("fifo_count", int'(fifo_count), m_q.size());
    if (ev_valid) obs_valid++;
    if (multi_err) obs_merr++;
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic press(input logic [11:0] s, input logic [7:0] d, input int hold, input int gap);
    sw = s; dipsw = d; step(hold);
    sw = '0; dipsw = '0; step(gap);
  endtask

  task automatic wait_ev(input int kind, input int code, input string nm);
    int n;
    n = 0;
    while (!ev_valid && n < 40) begin step(1); n++; end
    if (ev_valid) begin
      chk({nm, "_kind"}, int'(ev_kind), kind);
      chk({nm, "_code"}, int'(ev_code), code);
    end else begin
      chk({nm, "_timeout"}, 0, 1);
    end
  endtask

  task automatic latency(input string nm, output int n);
    n = 0;
    do begin step(1); n++; end while (!ev_valid && n < 40);
    chk(nm, n, 8);  // first edge after change counts as 1; visible after D+3 more
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, "_valid"}, int'(ev_valid), 0);
    chk({nm, "_kind"}, int'(ev_kind), 0);
    chk({nm, "_code"}, int'(ev_code), 0);
    chk({nm, "_merr"}, int'(multi_err), 0);
    chk({nm, "_ovf"}, int'(overflow), 0);
    chk({nm, "_count"}, int'(fifo_count), 0);
  endtask

  initial begin
    int n;
    #1 rst = 1'b1;
    step(2);
    chk_reset_state("reset");
    rst = 1'b0;
    step(3);

    // Single digit, latency, re-press
    ev_ready = 1'b1;
    sw = 12'h040;
    latency("lat_digit5", n);
    chk("d5_kind", int'(ev_kind), 0);
    chk("d5_code", int'(ev_code), 5);
    step(1);
    chk("d5_one_cycle", int'(ev_valid), 0);
    step(12);
    sw = '0; step(10);
    sw = 12'h040;
    wait_ev(0, 5, "repress");
    step(12);
    sw = '0; step(10);

    // Bounce rejection
    obs_valid = 0; obs_merr = 0;
    for (int i = 0; i < 5; i++) begin
      sw = 12'h800; step(2);
      sw = '0;      step(2);
    end
    step(15);
    chk("bounce_valid", obs_valid, 0);
    chk("bounce_merr", obs_merr, 0);

    // Operator then clear
    dipsw = 8'h01;
    wait_ev(1, 7, "op_eq");
    step(5); dipsw = '0; step(10);
    sw = 12'h001;
    wait_ev(2, 0, "clear");
    step(5); sw = '0; step(10);

    // Multi-key
    obs_valid = 0; obs_merr = 0;
    sw = 12'h800; dipsw = 8'h80;
    step(15);
    chk("multi_pulses", obs_merr, 1);
    chk("multi_no_event", obs_valid, 0);
    chk("multi_count", int'(fifo_count), 0);
    sw = '0; dipsw = '0; step(10);
    sw = 12'h004;
    wait_ev(0, 9, "digit9");
    step(5); sw = '0; step(10);

    // Overflow
    ev_ready = 1'b0;
    for (int i = 1; i <= 5; i++) press(12'h800 >> i, 8'h00, 10, 10);
    chk("ovf_count", int'(fifo_count), 4);
    chk("ovf_flag", int'(overflow), 1);
    chk("ovf_head", int'(ev_code), 1);
    ev_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_valid", int'(ev_valid), 1);
      chk("drain_code", int'(ev_code), i);
      step(1);
    end
    chk("drained_valid", int'(ev_valid), 0);
    ev_ready = 1'b0;

    // Simultaneous push/pop when full
    rst = 1'b1; step(1); rst = 1'b0; step(3);
    for (int i = 1; i <= 4; i++) press(12'h800 >> i, 8'h00, 10, 10);
    chk("refill_count", int'(fifo_count), 4);
    sw = 12'h800 >> 6;
    step(7);
    ev_ready = 1'b1; step(1); ev_ready = 1'b0;
    chk("pp_count", int'(fifo_count), 4);
    chk("pp_ovf", int'(overflow), 0);
    step(5); sw = '0; step(10);
    ev_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("pp_drain", int'(ev_code), (i == 3) ? 6 : i + 2);
      step(1);
    end
    chk("pp_empty", int'(ev_valid), 0);
    ev_ready = 1'b0;

    // Reset mid-operation
    press(12'h800 >> 7, 8'h00, 10, 10);
    press(12'h800 >> 8, 8'h00, 10, 10);
    chk("pre_rst_count", int'(fifo_count), 2);
    sw = 12'h100;
    step(3);
    rst = 1'b1; step(2);
    chk_reset_state("mid_rst");
    rst = 1'b0;
    latency("lat_after_rst", n);
    chk("rst_d3_kind", int'(ev_kind), 0);
    chk("rst_d3_code", int'(ev_code), 3);
    step(5); sw = '0; step(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
